// File: rtl/matmul_pkg.sv
// Shared definitions for the result transmit path.
//   - default matrix geometry (9 elements of 16 bits, row-major R00..R22)
//   - default sync header byte
//   - sequencer state encoding (constants plus the enum built on them)
//   - frame_len(): bytes per frame for a given header/checksum setup
package matmul_pkg;

  localparam int         N_ELEM_DEF      = 9;
  localparam int         ELEM_W_DEF      = 16;
  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_SEND      = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_NEXT      = 3'd5;
  localparam logic [2:0] ST_FINISH    = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_LOAD      = ST_LOAD,
    S_SEND      = ST_SEND,
    S_WAIT_ACK  = ST_WAIT_ACK,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_NEXT      = ST_NEXT,
    S_FINISH    = ST_FINISH
  } seq_state_e;

  // Optional header + payload bytes + optional checksum.
  function automatic int frame_len(input int header_en, input int n_elem,
                                   input int elem_w, input int cksum_en);
    return header_en + n_elem * (elem_w / 8) + cksum_en;
  endfunction

endpackage

// File: rtl/tx_byte_handshake.sv
// Per-byte handshake engine toward uart_tx.
// The sequencer owns the state register; this block decodes its current
// phase into the transmit strobe and the phase-exit conditions, and keeps
// the acknowledge timeout counter.
//
// Handshake: tx_start is high for the single SEND cycle. uart_tx accepts by
// raising tx_busy (seen in WAIT_ACK); the byte has left when tx_busy falls
// again (seen in WAIT_DONE). No busy within ACK_TIMEOUT cycles of WAIT_ACK
// is reported as ack_timeout.
//
// Ports:
//   bclk, rst        clock, asynchronous active-high reset
//   clr              drop the counter (frame abort)
//   in_send          sequencer is in SEND
//   in_wait_ack      sequencer is in WAIT_ACK
//   in_wait_done     sequencer is in WAIT_DONE
//   tx_busy          uart_tx busy
//   tx_start         transmit strobe
//   ack_seen         WAIT_ACK may advance (busy observed)
//   ack_timeout      WAIT_ACK gave up (last allowed cycle, still no busy)
//   byte_done        WAIT_DONE may advance (busy dropped)
module tx_byte_handshake #(
  parameter int ACK_TIMEOUT = 8
) (
  input  logic bclk,
  input  logic rst,
  input  logic clr,
  input  logic in_send,
  input  logic in_wait_ack,
  input  logic in_wait_done,
  input  logic tx_busy,
  output logic tx_start,
  output logic ack_seen,
  output logic ack_timeout,
  output logic byte_done
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts the WAIT_ACK cycles already spent without busy; saturates so it
  // can never wrap even if the phase is held longer than expected.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || in_send) begin
      cnt_d = '0;
    end else if (in_wait_ack && !tx_busy && (cnt_q != CNT_W'(ACK_TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tx_start    = in_send;
  assign ack_seen    = in_wait_ack && tx_busy;
  // Fires on the ACK_TIMEOUT-th WAIT_ACK cycle; a busy arriving in that same
  // cycle still counts as an acknowledge.
  assign ack_timeout = in_wait_ack && !tx_busy && (cnt_q == CNT_W'(ACK_TIMEOUT - 1));
  assign byte_done   = in_wait_done && !tx_busy;

endmodule

// File: rtl/result_tx_sequencer.sv
// Serializes the Calculator's 3x3 result matrix into a UART byte stream:
//   [HEADER_BYTE] R00.hi R00.lo R01.hi ... R22.lo [XOR of payload bytes]
// The matrix is captured into a shadow register when a start is accepted,
// so the bus may change while the frame is on the line.
//
// Ports:
//   bclk, rst   clock, asynchronous active-high reset
//   start       one-cycle send request, honoured only when idle
//   abort       synchronous cancel; beats a coincident start
//   result      flat matrix, R00 at [ELEM_W-1:0]
//   tx_busy     uart_tx busy
//   tx_data     byte presented to uart_tx, stable from SEND to end of WAIT_DONE
//   tx_start    one-cycle transmit strobe
//   busy        frame in progress (any state but IDLE)
//   done        one-cycle pulse when a whole frame has gone out
//   error       sticky ack-timeout flag, cleared by the next accepted start
module result_tx_sequencer #(
  parameter int         N_ELEM      = matmul_pkg::N_ELEM_DEF,
  parameter int         ELEM_W      = matmul_pkg::ELEM_W_DEF,  // multiple of 8
  parameter int         HEADER_EN   = 1,
  parameter logic [7:0] HEADER_BYTE = matmul_pkg::HEADER_BYTE_DEF,
  parameter int         CKSUM_EN    = 1,
  parameter int         ACK_TIMEOUT = 8
) (
  input  logic                     bclk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [N_ELEM*ELEM_W-1:0] result,
  input  logic                     tx_busy,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  import matmul_pkg::*;

  localparam int BPE       = ELEM_W / 8;
  localparam int PAY_BYTES = N_ELEM * BPE;
  localparam int FRAME_LEN = frame_len(HEADER_EN, N_ELEM, ELEM_W, CKSUM_EN);
  localparam int IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int RES_W     = N_ELEM * ELEM_W;
  localparam int BIT_W     = $clog2(RES_W);

  seq_state_e       state_q, state_d;
  logic [RES_W-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       cksum_q, cksum_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             error_q, error_d;

  logic             hs_tx_start, ack_seen, ack_timeout, byte_done;

  // ---------------------------------------------------------------------
  // Byte selection for the current index
  // ---------------------------------------------------------------------
  int               pay_k;
  logic             is_header, is_payload;
  logic [BIT_W-1:0] pay_lsb;
  logic [7:0]       pay_byte, sel_byte;

  always_comb begin
    pay_k      = int'(idx_q) - HEADER_EN;
    is_header  = (HEADER_EN != 0) && (idx_q == '0);
    is_payload = (pay_k >= 0) && (pay_k < PAY_BYTES);
    pay_lsb    = '0;
    // Element pay_k/BPE, byte pay_k%BPE counted from its MSB (big-endian).
    if (is_payload) begin
      pay_lsb = BIT_W'((pay_k / BPE) * ELEM_W + ELEM_W - 8 - 8 * (pay_k % BPE));
    end
    pay_byte = shadow_q[pay_lsb +: 8];
    if (is_header) begin
      sel_byte = HEADER_BYTE;
    end else if (is_payload) begin
      sel_byte = pay_byte;
    end else begin
      sel_byte = cksum_q;
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    idx_d     = idx_q;
    cksum_d   = cksum_q;
    tx_data_d = tx_data_q;
    error_d   = error_q;

    if (abort) begin
      // Leaves any active state; in IDLE this just swallows a coincident
      // start. A byte already taken by uart_tx finishes on its own.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shadow_d = result;
            idx_d    = '0;
            cksum_d  = '0;
            error_d  = 1'b0;
            state_d  = S_LOAD;
          end
        end
        S_LOAD: begin
          tx_data_d = sel_byte;
          state_d   = S_SEND;
        end
        S_SEND: begin
          state_d = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (ack_seen) begin
            state_d = S_WAIT_DONE;
          end else if (ack_timeout) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_WAIT_DONE: begin
          if (byte_done) begin
            state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          if (is_payload) begin
            cksum_d = cksum_q ^ tx_data_q;
          end
          if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
        S_FINISH: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      idx_q     <= '0;
      cksum_q   <= '0;
      tx_data_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      idx_q     <= idx_d;
      cksum_q   <= cksum_d;
      tx_data_q <= tx_data_d;
      error_q   <= error_d;
    end
  end

  tx_byte_handshake #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_handshake (
    .bclk         (bclk),
    .rst          (rst),
    .clr          (abort),
    .in_send      (state_q == S_SEND),
    .in_wait_ack  (state_q == S_WAIT_ACK),
    .in_wait_done (state_q == S_WAIT_DONE),
    .tx_busy      (tx_busy),
    .tx_start     (hs_tx_start),
    .ack_seen     (ack_seen),
    .ack_timeout  (ack_timeout),
    .byte_done    (byte_done)
  );

  assign tx_data  = tx_data_q;
  assign tx_start = hs_tx_start;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FINISH);
  assign error    = error_q;

endmodule

// File: tb/tb_result_tx_sequencer.sv
// Directed bench for result_tx_sequencer.
// Instance 0: default parameters. Instance 1: no header, no checksum.
// Each instance has a small uart_tx model: busy rises one cycle after
// tx_start and stays high for 10 cycles (or never rises when "dead").
`timescale 1ns/1ps
module tb_result_tx_sequencer;

  localparam int RES_W = 144;

  // ---------------- clock / reset ----------------
  logic bclk = 1'b0;
  always #5 bclk = ~bclk;

  logic             rst_r     [2];
  logic             start_r   [2];
  logic             abort_r   [2];
  logic [RES_W-1:0] result;
  logic             tx_busy_r [2] = '{1'b0, 1'b0};

  logic [7:0]       tx_data_w  [2];
  logic             tx_start_w [2];
  logic             busy_w     [2];
  logic             done_w     [2];
  logic             error_w    [2];

  result_tx_sequencer u_dut0 (
    .bclk     (bclk),
    .rst      (rst_r[0]),
    .start    (start_r[0]),
    .abort    (abort_r[0]),
    .result   (result),
    .tx_busy  (tx_busy_r[0]),
    .tx_data  (tx_data_w[0]),
    .tx_start (tx_start_w[0]),
    .busy     (busy_w[0]),
    .done     (done_w[0]),
    .error    (error_w[0])
  );

  result_tx_sequencer #(
    .HEADER_EN (0),
    .CKSUM_EN  (0)
  ) u_dut1 (
    .bclk     (bclk),
    .rst      (rst_r[1]),
    .start    (start_r[1]),
    .abort    (abort_r[1]),
    .result   (result),
    .tx_busy  (tx_busy_r[1]),
    .tx_data  (tx_data_w[1]),
    .tx_start (tx_start_w[1]),
    .busy     (busy_w[1]),
    .done     (done_w[1]),
    .error    (error_w[1])
  );

  // ---------------- uart_tx models ----------------
  int         n_starts  [2];
  int         n_dones   [2];
  int         busy_left [2];
  bit         pend      [2];
  bit         dead      [2];
  logic [7:0] rx0_q[$];
  logic [7:0] rx1_q[$];

  always @(negedge bclk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy_left[i] > 0) begin
        busy_left[i]--;
        if (busy_left[i] == 0) tx_busy_r[i] = 1'b0;
      end
      if (pend[i]) begin
        pend[i]      = 1'b0;
        tx_busy_r[i] = 1'b1;
        busy_left[i] = 10;
      end
      if (tx_start_w[i] === 1'b1) begin
        n_starts[i]++;
        if (i == 0) rx0_q.push_back(tx_data_w[i]);
        else        rx1_q.push_back(tx_data_w[i]);
        if (!dead[i]) pend[i] = 1'b1;
      end
      if (done_w[i] === 1'b1) n_dones[i]++;
    end
  end

  // ---------------- scoreboard ----------------
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sampling point: just after the falling edge, after the uart model.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge bclk);
      #1;
    end
  endtask

  // Expected frame for a captured matrix; compares n_take received bytes
  // starting at queue position first.
  task automatic check_frame(input int inst, input logic [RES_W-1:0] res,
                             input bit hdr, input bit ck, input int first,
                             input int n_take, input string tag);
    logic [7:0] got_q[$];
    logic [7:0] acc;
    exp_q.delete();
    acc = 8'h00;
    if (hdr) exp_q.push_back(8'hA5);
    for (int e = 0; e < 9; e++) begin
      logic [7:0] hi, lo;
      hi = res[e*16+8 +: 8];
      lo = res[e*16 +: 8];
      exp_q.push_back(hi);
      exp_q.push_back(lo);
      acc = acc ^ hi ^ lo;
    end
    if (ck) exp_q.push_back(acc);
    if (inst == 0) got_q = rx0_q;
    else           got_q = rx1_q;
    chk({tag, "_len"}, 32'(got_q.size() - first), 32'(n_take));
    for (int i = 0; i < n_take && (first + i) < got_q.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i), {24'h0, got_q[first + i]}, {24'h0, exp_q[i]});
    end
  endtask

  task automatic wait_idle(input int inst, input int budget, input string tag);
    int n;
    n = 0;
    while (busy_w[inst] === 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_idle"}, {31'h0, busy_w[inst]}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  logic [RES_W-1:0] res_a, res_b;
  int base_s, base_d, base_rx, n;

  initial begin
    // R00..R22 = 0102, 0304, ..., 1112 -> payload bytes 01..12, XOR = 13
    for (int e = 0; e < 9; e++) begin
      res_a[e*16 +: 16] = {8'(2*e + 1), 8'(2*e + 2)};
      res_b[e*16 +: 16] = 16'hC000 | 16'(e * 16'h0111);
    end
    result = res_a;
    for (int i = 0; i < 2; i++) begin
      rst_r[i]   = 1'b1;
      start_r[i] = 1'b0;
      abort_r[i] = 1'b0;
    end

    // ---- reset state ----
    tick(2);
    chk("rst_tx_data",  {24'h0, tx_data_w[0]}, 32'h0);
    chk("rst_tx_start", {31'h0, tx_start_w[0]}, 32'h0);
    chk("rst_busy",     {31'h0, busy_w[0]}, 32'h0);
    chk("rst_done",     {31'h0, done_w[0]}, 32'h0);
    chk("rst_error",    {31'h0, error_w[0]}, 32'h0);
    rst_r[0] = 1'b0;
    rst_r[1] = 1'b0;
    tick(2);

    // ---- 1: default frame, latency, pulse counts ----
    base_s = n_starts[0]; base_d = n_dones[0]; base_rx = rx0_q.size();
    start_r[0] = 1'b1;
    tick(1);
    start_r[0] = 1'b0;
    chk("lat_load_busy",     {31'h0, busy_w[0]}, 32'h1);
    chk("lat_load_tx_start", {31'h0, tx_start_w[0]}, 32'h0);
    tick(1);
    chk("lat_send_tx_start", {31'h0, tx_start_w[0]}, 32'h1);
    chk("lat_send_tx_data",  {24'h0, tx_data_w[0]}, 32'hA5);
    wait_idle(0, 1000, "f1");
    chk("f1_starts", 32'(n_starts[0] - base_s), 32'd20);
    chk("f1_dones",  32'(n_dones[0] - base_d), 32'd1);
    chk("f1_error",  {31'h0, error_w[0]}, 32'h0);
    check_frame(0, res_a, 1'b1, 1'b1, base_rx, 20, "f1");
    tick(3);

    // ---- 2: result changes mid-frame ----
    result = res_b;
    base_rx = rx0_q.size();
    start_r[0] = 1'b1;
    tick(1);
    start_r[0] = 1'b0;
    tick(25);
    result = '1;
    wait_idle(0, 1000, "f2");
    check_frame(0, res_b, 1'b1, 1'b1, base_rx, 20, "f2");
    result = res_a;
    tick(3);

    // ---- 3: no acknowledge -> timeout error, then recovery ----
    dead[0] = 1'b1;
    base_s = n_starts[0]; base_d = n_dones[0];
    start_r[0] = 1'b1;
    tick(1);
    start_r[0] = 1'b0;
    tick(9);
    chk("to_still_busy", {31'h0, busy_w[0]}, 32'h1);
    chk("to_err_early",  {31'h0, error_w[0]}, 32'h0);
    tick(1);
    chk("to_idle",   {31'h0, busy_w[0]}, 32'h0);
    chk("to_error",  {31'h0, error_w[0]}, 32'h1);
    chk("to_starts", 32'(n_starts[0] - base_s), 32'd1);
    tick(3);
    chk("to_error_sticky", {31'h0, error_w[0]}, 32'h1);
    chk("to_no_done", 32'(n_dones[0] - base_d), 32'd0);
    dead[0] = 1'b0;
    base_s = n_starts[0]; base_d = n_dones[0]; base_rx = rx0_q.size();
    start_r[0] = 1'b1;
    tick(1);
    start_r[0] = 1'b0;
    chk("rec_error_clr", {31'h0, error_w[0]}, 32'h0);
    wait_idle(0, 1000, "rec");
    chk("rec_dones", 32'(n_dones[0] - base_d), 32'd1);
    check_frame(0, res_a, 1'b1, 1'b1, base_rx, 20, "rec");
    tick(3);

    // ---- 4: abort after the 5th byte's tx_start ----
    base_s = n_starts[0]; base_d = n_dones[0]; base_rx = rx0_q.size();
    start_r[0] = 1'b1;
    tick(1);
    start_r[0] = 1'b0;
    n = 0;
    while ((n_starts[0] - base_s) < 5 && n < 500) begin
      tick(1);
      n++;
    end
    chk("ab_reach_5th", {31'h0, tx_start_w[0]}, 32'h1);
    abort_r[0] = 1'b1;
    tick(1);
    abort_r[0] = 1'b0;
    chk("ab_busy",     {31'h0, busy_w[0]}, 32'h0);
    chk("ab_tx_start", {31'h0, tx_start_w[0]}, 32'h0);
    tick(40);
    chk("ab_starts", 32'(n_starts[0] - base_s), 32'd5);
    chk("ab_dones",  32'(n_dones[0] - base_d), 32'd0);
    chk("ab_error",  {31'h0, error_w[0]}, 32'h0);
    check_frame(0, res_a, 1'b1, 1'b1, base_rx, 5, "ab");

    // ---- 5: start+abort in IDLE, start re-pulsed mid-frame ----
    base_s = n_starts[0]; base_d = n_dones[0]; base_rx = rx0_q.size();
    start_r[0] = 1'b1;
    abort_r[0] = 1'b1;
    tick(1);
    start_r[0] = 1'b0;
    abort_r[0] = 1'b0;
    chk("sa_busy", {31'h0, busy_w[0]}, 32'h0);
    tick(3);
    chk("sa_starts", 32'(n_starts[0] - base_s), 32'd0);
    start_r[0] = 1'b1;
    tick(1);
    start_r[0] = 1'b0;
    tick(30);
    start_r[0] = 1'b1;
    tick(1);
    start_r[0] = 1'b0;
    wait_idle(0, 1000, "rp");
    tick(20);
    chk("rp_stays_idle", {31'h0, busy_w[0]}, 32'h0);
    chk("rp_starts", 32'(n_starts[0] - base_s), 32'd20);
    chk("rp_dones",  32'(n_dones[0] - base_d), 32'd1);
    check_frame(0, res_a, 1'b1, 1'b1, base_rx, 20, "rp");

    // ---- 6: no header / no checksum, async reset mid-WAIT_DONE ----
    base_s = n_starts[1]; base_d = n_dones[1]; base_rx = rx1_q.size();
    start_r[1] = 1'b1;
    tick(1);
    start_r[1] = 1'b0;
    chk("nh_first_byte_lat", {31'h0, tx_start_w[1]}, 32'h0);
    tick(1);
    chk("nh_first_byte", {24'h0, tx_data_w[1]}, 32'h01);
    wait_idle(1, 1000, "nh");
    chk("nh_starts", 32'(n_starts[1] - base_s), 32'd18);
    chk("nh_dones",  32'(n_dones[1] - base_d), 32'd1);
    check_frame(1, res_a, 1'b0, 1'b0, base_rx, 18, "nh");
    tick(3);

    base_s = n_starts[1];
    start_r[1] = 1'b1;
    tick(1);
    start_r[1] = 1'b0;
    n = 0;
    while ((n_starts[1] - base_s) < 3 && n < 500) begin
      tick(1);
      n++;
    end
    tick(3);
    chk("ar_in_wait_done", {30'h0, busy_w[1], tx_busy_r[1]}, 32'h3);
    rst_r[1] = 1'b1;
    #1;
    chk("ar_tx_data",  {24'h0, tx_data_w[1]}, 32'h0);
    chk("ar_tx_start", {31'h0, tx_start_w[1]}, 32'h0);
    chk("ar_busy",     {31'h0, busy_w[1]}, 32'h0);
    chk("ar_done",     {31'h0, done_w[1]}, 32'h0);
    chk("ar_error",    {31'h0, error_w[1]}, 32'h0);
    tick(1);
    rst_r[1] = 1'b0;
    tick(20);
    result = res_b;
    base_d = n_dones[1]; base_rx = rx1_q.size();
    start_r[1] = 1'b1;
    tick(1);
    start_r[1] = 1'b0;
    wait_idle(1, 1000, "ar2");
    chk("ar2_dones", 32'(n_dones[1] - base_d), 32'd1);
    check_frame(1, res_b, 1'b0, 1'b0, base_rx, 18, "ar2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
